ccff_chain_loader: RTL

Configuration-chain loader for the logic-tile programming path. It accepts a bitstream as words over a valid/ready stream and serialises it onto the ccff_head of a tile's configuration flip-flop chain, one bit per prog_clk. It drives the shift-enable that gates the chain's programming clock. Optionally, it verifies the loaded contents by rotating the chain through ccff_tail and comparing CRCs. It sits between the bitstream source and the ccff_head/ccff_tail ports of the CLB/fle hierarchy.

---
 rtl/ccff_chain_loader_pkg.sv | 21 ++
 rtl/ccff_chain_loader_if.sv | 12 +
 rtl/ccff_crc16_serial.sv | 24 ++
 rtl/ccff_chain_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
// The CRC is CRC-16-CCITT advanced one bit per call, MSB-first feedback.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the loader; a word moves when s_valid && s_ready.
// Latency/backpressure are owned by the consumer (ready may drop at any cycle).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Serial CRC-16, one bit per enabled cycle, clear has priority; 1-cycle update latency.
// Only built with CCFF_READBACK_EN; no backpressure (sampled whenever en is high).
`ifdef CCFF_READBACK_EN
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        pReset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge prog_clk) begin
    if (pReset || clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words onto ccff_head, 1 bit/prog_clk; a word's bit 0 shifts the cycle after acceptance.
// s_ready only in LOAD when the buffer empties this cycle; empty buffer stalls the chain. CCFF_READBACK_EN adds CRC verify.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 65,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  ccff_chain_loader_if.slave   s,
  output logic                 ccff_head,
  input  logic                 ccff_tail,
  output logic                 cfg_shift_en,
  output logic                 busy,
  output logic                 done,
  output logic                 verify_ok,
  output logic [CNT_W-1:0]     bit_count
);

  localparam int BC_W = $clog2(WORD_W + 1);

  state_t            state_q, state_n;
  logic [WORD_W-1:0] buf_q, buf_n;
  logic [BC_W-1:0]   buf_cnt_q, buf_cnt_n, word_bits;
  logic [CNT_W-1:0]  bit_count_q, bit_count_n;
  logic              head_q, head_n, en_q, en_n;
  logic              verify_ok_q, verify_ok_n;
  logic [CNT_W:0]    committed, remaining;
  logic              shift, accept;
  logic              tail_match;

  // Bits already shifted plus bits still waiting in the buffer; the final word is trimmed to what is left.
  always_comb begin
    committed = (CNT_W+1)'(bit_count_q) + (CNT_W+1)'(buf_cnt_q);
    remaining = (CNT_W+1)'(CHAIN_LEN) - committed;
    word_bits = (remaining < (CNT_W+1)'(WORD_W)) ? BC_W'(remaining) : BC_W'(WORD_W);
  end

  assign shift     = (state_q == LOAD) && (buf_cnt_q != '0);
  assign s.s_ready = (state_q == LOAD) && (buf_cnt_q <= BC_W'(1))
                     && (committed < (CNT_W+1)'(CHAIN_LEN));
  assign accept    = s.s_valid && s.s_ready;

`ifdef CCFF_READBACK_EN
  logic [15:0] load_crc, tail_crc;
  logic        crc_clr;

  assign crc_clr    = (state_q == IDLE) && start;
  assign tail_match = (crc16_step(tail_crc, ccff_tail) == load_crc);

  ccff_crc16_serial u_load_crc (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .clr      (crc_clr),
    .en       (shift),
    .din      (head_q),
    .crc      (load_crc)
  );

  ccff_crc16_serial u_tail_crc (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .clr      (crc_clr),
    .en       (state_q == VERIFY),
    .din      (ccff_tail),
    .crc      (tail_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign tail_match  = 1'b1;
`endif

  always_comb begin
    state_n     = state_q;
    buf_n       = buf_q;
    buf_cnt_n   = buf_cnt_q;
    bit_count_n = bit_count_q;
    verify_ok_n = verify_ok_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n     = LOAD;
          buf_n       = '0;
          buf_cnt_n   = '0;
          bit_count_n = '0;
          verify_ok_n = 1'b0;
        end
      end
      LOAD: begin
        if (shift) begin
          buf_n       = buf_q >> 1;
          buf_cnt_n   = buf_cnt_q - BC_W'(1);
          bit_count_n = bit_count_q + CNT_W'(1);
        end
        if (accept) begin
          buf_n     = s.s_data;
          buf_cnt_n = word_bits;
        end
        if (shift && (bit_count_q == CNT_W'(CHAIN_LEN - 1))) begin
`ifdef CCFF_READBACK_EN
          state_n     = VERIFY;
          bit_count_n = '0;
`else
          state_n     = DONE;
          verify_ok_n = 1'b1;
`endif
        end
      end
      VERIFY: begin
        bit_count_n = bit_count_q + CNT_W'(1);
        if (bit_count_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_n     = DONE;
          verify_ok_n = tail_match;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Output stage shows next cycle's buffer head so the chain sees flop outputs only.
    head_n = (state_n == LOAD) && buf_n[0];
    en_n   = ((state_n == LOAD) && (buf_cnt_n != '0)) || (state_n == VERIFY);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      bit_count_q <= '0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      verify_ok_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      buf_q       <= buf_n;
      buf_cnt_q   <= buf_cnt_n;
      bit_count_q <= bit_count_n;
      head_q      <= head_n;
      en_q        <= en_n;
      verify_ok_q <= verify_ok_n;
    end
  end

`ifdef CCFF_READBACK_EN
  // During verify the tail is looped straight back so the rotation is exactly CHAIN_LEN long.
  assign ccff_head = (state_q == VERIFY) ? ccff_tail : head_q;
`else
  assign ccff_head = head_q;
`endif
  assign cfg_shift_en = en_q;
  assign busy         = (state_q == LOAD) || (state_q == VERIFY);
  assign done         = (state_q == DONE);
  assign verify_ok    = verify_ok_q;
  assign bit_count    = bit_count_q;

endmodule
